// File: rtl/envelope_bank.sv
`default_nettype none
// ============================================================================
// Module   : envelope_bank
// Brief    : Eight-voice ADSR envelope generator, one shared time-multiplexed
//            update datapath evaluating one voice per clock within a sweep.
// Revision : 1.0
// ============================================================================
module envelope_bank #(
  parameter int          TICK_DIV  = 16,
  parameter logic [31:0] LEVEL_MAX = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  gate,
  input  logic [31:0] attack_step,
  input  logic [31:0] decay_step,
  input  logic [31:0] sustain_level,
  input  logic [31:0] release_step,
  output logic [31:0] voice_volumes [7:0],
  output logic [7:0]  active
);

  localparam int             DIV_W      = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  logic [DIV_W-1:0] r_div;
  state_t           r_state [7:0];
  logic [31:0]      r_level [7:0];
  logic [7:0]       r_gate_q;
  logic [7:0]       r_rise_pending;
  logic [7:0]       r_active;

  logic             w_slot_valid;
  logic [2:0]       w_slot;
  logic [7:0]       w_slot_mask;
  logic [7:0]       w_pend;
  state_t           w_cur_state;
  logic [31:0]      w_cur_level;
  state_t           w_eff_state;
  state_t           w_nxt_state;
  logic [31:0]      w_nxt_level;
  logic [31:0]      w_sustain;
  logic [32:0]      w_att_sum;
  logic [32:0]      w_dec_floor;

  assign w_slot_valid = (32'(r_div) < 32'd8);
  assign w_slot       = r_div[2:0];
  assign w_slot_mask  = w_slot_valid ? (8'd1 << w_slot) : 8'd0;
  // A rise seen in the slot cycle itself is honoured, not lost to the clear.
  assign w_pend       = r_rise_pending | (gate & ~r_gate_q);

  assign w_cur_state  = r_state[w_slot];
  assign w_cur_level  = r_level[w_slot];
  assign w_sustain    = (sustain_level > LEVEL_MAX) ? LEVEL_MAX : sustain_level;
  assign w_att_sum    = {1'b0, w_cur_level} + {1'b0, attack_step};
  assign w_dec_floor  = {1'b0, w_sustain} + {1'b0, decay_step};

  always_comb begin
    w_eff_state = w_cur_state;
    if (w_pend[w_slot]) begin
      w_eff_state = ST_ATTACK;
    end else if (!gate[w_slot] &&
                 (w_cur_state == ST_ATTACK || w_cur_state == ST_DECAY ||
                  w_cur_state == ST_SUSTAIN)) begin
      w_eff_state = ST_RELEASE;
    end
  end

  // Subtractions are guarded by compares so the level never wraps below 0.
  always_comb begin
    w_nxt_state = w_eff_state;
    w_nxt_level = w_cur_level;
    case (w_eff_state)
      ST_ATTACK: begin
        if (attack_step == 32'd0 || w_att_sum >= {1'b0, LEVEL_MAX}) begin
          w_nxt_level = LEVEL_MAX;
          w_nxt_state = ST_DECAY;
        end else begin
          w_nxt_level = w_att_sum[31:0];
        end
      end
      ST_DECAY: begin
        if (decay_step == 32'd0 || {1'b0, w_cur_level} <= w_dec_floor) begin
          w_nxt_level = w_sustain;
          w_nxt_state = ST_SUSTAIN;
        end else begin
          w_nxt_level = w_cur_level - decay_step;
        end
      end
      ST_SUSTAIN: begin
        w_nxt_level = w_sustain;
      end
      ST_RELEASE: begin
        if (release_step == 32'd0 || w_cur_level <= release_step) begin
          w_nxt_level = 32'd0;
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_level = w_cur_level - release_step;
        end
      end
      default: begin
        w_nxt_level = 32'd0;
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div          <= '0;
      r_gate_q       <= 8'd0;
      r_rise_pending <= 8'd0;
      r_active       <= 8'd0;
      for (int v = 0; v < 8; v++) begin
        r_state[v] <= ST_IDLE;
        r_level[v] <= 32'd0;
      end
    end else begin
      r_div          <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
      r_gate_q       <= gate;
      r_rise_pending <= w_pend & ~w_slot_mask;
      if (w_slot_valid) begin
        r_state[w_slot]  <= w_nxt_state;
        r_level[w_slot]  <= w_nxt_level;
        r_active[w_slot] <= (w_nxt_state != ST_IDLE);
      end
    end
  end

  generate
    for (genvar g = 0; g < 8; g++) begin : g_out
      assign voice_volumes[g] = r_level[g];
    end
  endgenerate

  assign active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_envelope_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_envelope_bank
// Brief    : Scoreboard bench: expected per-voice output changes are queued
//            by stimulus and popped by a monitor whenever an output changes.
// Revision : 1.0
// ============================================================================
module tb_envelope_bank;

  typedef struct packed {
    logic [31:0] lvl;
    logic        act;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [7:0]  gate;
  logic [31:0] attack_step, decay_step, sustain_level, release_step;
  logic [31:0] vol [7:0];
  logic [7:0]  act;

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  exp_t exp_q [8][$];

  envelope_bank #(.TICK_DIV(16), .LEVEL_MAX(32'h0001_0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .voice_volumes (vol),
    .active        (act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; edge k (1-based) ends the cycle with div (k-1)%16.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  logic [31:0] prev_vol [7:0];
  logic [7:0]  prev_act;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      for (int v = 0; v < 8; v++) begin
        if (vol[v] !== prev_vol[v] || act[v] !== prev_act[v]) begin
          checks++;
          if (((edge_n - 1) % 16) != v) begin
            errors++;
            $display("FAIL timing v%0d: changed after div %0d, required div %0d",
                     v, (edge_n - 1) % 16, v);
          end
          checks++;
          if (exp_q[v].size() == 0) begin
            errors++;
            $display("FAIL unexpected v%0d: vol %h act %b, required no change",
                     v, vol[v], act[v]);
          end else begin
            e = exp_q[v].pop_front();
            if (vol[v] !== e.lvl || act[v] !== e.act) begin
              errors++;
              $display("FAIL level v%0d: vol %h act %b, required vol %h act %b",
                       v, vol[v], act[v], e.lvl, e.act);
            end
          end
        end
      end
    end
    for (int v = 0; v < 8; v++) prev_vol[v] = vol[v];
    prev_act = act;
  end

  task automatic push(input int v, input logic [31:0] l, input logic a);
    exp_q[v].push_back({l, a});
  endtask

  task automatic wait_drain(input int v, input int budget);
    int n = 0;
    while (exp_q[v].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q[v].size() != 0) begin
      errors++;
      $display("FAIL drain v%0d: %0d entries pending, required 0", v, exp_q[v].size());
      exp_q[v].delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    gate          = 8'hFF;
    attack_step   = 32'h4000;
    decay_step    = 32'h0;
    sustain_level = 32'h1_0000;
    release_step  = 32'h0;

    // Reset holds everything at zero even with all gates high.
    idle(3);
    for (int v = 0; v < 8; v++) begin
      checks++;
      if (vol[v] !== 32'd0) begin
        errors++;
        $display("FAIL reset_vol v%0d: got %h, required 0", v, vol[v]);
      end
    end
    checks++;
    if (act !== 8'h00) begin
      errors++;
      $display("FAIL reset_active: got %h, required 00", act);
    end

    // Release reset with gates held: every voice attacks, voice 0 first at div 0.
    for (int v = 0; v < 8; v++) begin
      push(v, 32'h4000, 1'b1);
      push(v, 32'h8000, 1'b1);
      push(v, 32'hC000, 1'b1);
      push(v, 32'h1_0000, 1'b1);
    end
    reset_n = 1'b1;
    for (int v = 0; v < 8; v++) wait_drain(v, 200);
    for (int v = 0; v < 8; v++) push(v, 32'h0, 1'b0);
    gate = 8'h00;
    for (int v = 0; v < 8; v++) wait_drain(v, 100);

    // Full ADSR on voice 2.
    attack_step = 32'h4000; decay_step = 32'h2000;
    sustain_level = 32'h8000; release_step = 32'h1000;
    push(2, 32'h4000, 1); push(2, 32'h8000, 1); push(2, 32'hC000, 1);
    push(2, 32'h1_0000, 1); push(2, 32'hE000, 1); push(2, 32'hC000, 1);
    push(2, 32'hA000, 1); push(2, 32'h8000, 1);
    gate[2] = 1'b1;
    wait_drain(2, 300);
    idle(48);
    for (int l = 32'h7000; l >= 32'h1000; l -= 32'h1000) push(2, 32'(l), 1'b1);
    push(2, 32'h0, 1'b0);
    gate[2] = 1'b0;
    wait_drain(2, 300);

    // Retrigger voice 1 during release at 0x6000.
    push(1, 32'h4000, 1); push(1, 32'h8000, 1); push(1, 32'hC000, 1);
    push(1, 32'h1_0000, 1); push(1, 32'hE000, 1); push(1, 32'hC000, 1);
    push(1, 32'hA000, 1); push(1, 32'h8000, 1);
    gate[1] = 1'b1;
    wait_drain(1, 300);
    push(1, 32'h7000, 1); push(1, 32'h6000, 1);
    gate[1] = 1'b0;
    wait_drain(1, 100);
    push(1, 32'hA000, 1);
    gate[1] = 1'b1;
    wait_drain(1, 40);
    for (int l = 32'h9000; l >= 32'h1000; l -= 32'h1000) push(1, 32'(l), 1'b1);
    push(1, 32'h0, 1'b0);
    gate[1] = 1'b0;
    wait_drain(1, 300);

    // Zero steps with over-range sustain on voice 4.
    attack_step = 32'h0; decay_step = 32'h0;
    sustain_level = 32'h2_0000; release_step = 32'h0;
    push(4, 32'h1_0000, 1'b1);
    gate[4] = 1'b1;
    wait_drain(4, 40);
    idle(48);
    push(4, 32'h0, 1'b0);
    gate[4] = 1'b0;
    wait_drain(4, 40);

    // One-clock gate pulse on voice 5 during div 9.
    attack_step = 32'h3000; decay_step = 32'h1000;
    sustain_level = 32'h8000; release_step = 32'h1000;
    push(5, 32'h3000, 1); push(5, 32'h2000, 1);
    push(5, 32'h1000, 1); push(5, 32'h0, 0);
    for (int n = 0; n < 32 && (edge_n % 16) != 9; n++) @(negedge clk);
    gate[5] = 1'b1;
    @(negedge clk);
    gate[5] = 1'b0;
    wait_drain(5, 100);

    // Voices 0 and 7 together, attack saturating without wrap.
    attack_step = 32'hFFFF_FFFF; decay_step = 32'h0;
    sustain_level = 32'h4000; release_step = 32'h0;
    push(0, 32'h1_0000, 1); push(0, 32'h4000, 1);
    push(7, 32'h1_0000, 1); push(7, 32'h4000, 1);
    gate = 8'h81;
    wait_drain(0, 60);
    wait_drain(7, 60);
    push(0, 32'h0, 0); push(7, 32'h0, 0);
    gate = 8'h00;
    wait_drain(0, 40);
    wait_drain(7, 40);

    idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/envelope_bank.md
# envelope_bank

Eight-voice ADSR envelope generator that sits directly upstream of the synthesizer and drives its per-voice `voice_volumes` inputs. Each voice follows a gate bit through attack, decay, sustain and release, and produces a Q16 gain where 0x0001_0000 is unity. The eight voices share one time-multiplexed update datapath, with one voice processed per clock inside a periodic sweep. `active` tells the note allocator which voices are still sounding.

## Interface
- `TICK_DIV`, default 16: clocks per envelope sweep (envelope rate); must be ≥ 8.
- `LEVEL_MAX`, default 32'h0001_0000: full-scale level (unity gain, Q16).
- `clk` in 1: system clock; the single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `gate` in 8: per-voice note gate; 1 means key held.
- `attack_step` in 32: level increment per sweep in ATTACK; 0 means instant.
- `decay_step` in 32: level decrement per sweep in DECAY; 0 means instant.
- `sustain_level` in 32: SUSTAIN target; values above `LEVEL_MAX` are treated as `LEVEL_MAX`.
- `release_step` in 32: level decrement per sweep in RELEASE; 0 means instant.
- `voice_volumes[7:0]` out 32 each: registered per-voice gain; feeds the synthesizer.
- `active` out 8: bit v = 1 while voice v is not IDLE.

## Operation
- **Per-voice state:** 3-bit state (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), 32-bit level, gate history bit, sticky `rise_pending` bit.
- **Sweep divider:** `div` counts 0..TICK_DIV-1 and wraps.
- **Slot:** when `div` == v (v < 8), voice v is evaluated. No evaluation happens when `div` ≥ 8.
- **Edge detection (every clock, independent of slots):**
  - A 0→1 transition of `gate[v]` sets `rise_pending[v]`.
  - `rise_pending[v]` clears at the end of voice v's slot.
- **Slot evaluation, in priority order:**
  1. If `rise_pending`: go to ATTACK. Level is kept (retrigger without click) and the attack step is applied in this same slot.
  2. Else if `gate[v]` == 0 and state is ATTACK, DECAY or SUSTAIN: go to RELEASE and apply the release step in this same slot.
  3. Else advance the current state:
     - **ATTACK:** level += `attack_step`. If the result ≥ LEVEL_MAX, or the step is 0: level = LEVEL_MAX, go to DECAY.
     - **DECAY:** if level − `decay_step` ≤ S (S = clamped sustain), or the step is 0: level = S, go to SUSTAIN. Otherwise level −= `decay_step`.
     - **SUSTAIN:** level = S. This tracks live changes to `sustain_level`.
     - **RELEASE:** if level ≤ `release_step`, or the step is 0: level = 0, go to IDLE. Otherwise level −= `release_step`.
     - **IDLE:** level = 0.
- **Arithmetic:**
  - All arithmetic is unsigned 32-bit.
  - Attack addition uses a 33-bit sum, so overflow saturates to LEVEL_MAX.
  - Subtractions are compared before subtracting and never wrap below 0.
- **Short gate pulse:** a pulse that rises and falls between two slots gives one attack step in slot k, then RELEASE from slot k+1.

## Timing
- **Reset (asynchronous, `reset_n` low):**
  - `div` = 0; all states IDLE, levels 0, gate history 0, `rise_pending` 0.
  - All `voice_volumes` = 0; `active` = 0.
  - Effective immediately, including mid-sweep. The first slot after release of reset is voice 0 at `div` == 0.
- **Latency:**
  - `voice_volumes[v]` and `active[v]` update on the clock edge that ends voice v's slot cycle.
  - They hold stable for the other TICK_DIV−1 cycles.
- **Gate rise to first nonzero volume:** at most TICK_DIV + 1 clocks.
- **Parameter sampling:** the step and sustain inputs are sampled in the slot cycle only. Changes between slots have no effect until the next slot.
- **Update order:** voice order within a sweep is fixed 0..7. Outputs never change when `div` ≥ 8.

## Test plan
- **Reset:** hold `reset_n`=0 with gate=8'hFF → all `voice_volumes` 0 and `active` 0. Release reset → voice 0 enters ATTACK at `div`=0.
- **Full ADSR on voice 2:** attack 0x4000, decay 0x2000, sustain 0x8000, release 0x1000; gate[2] high. Required:
  - levels 0x4000, 0x8000, 0xC000, 0x10000 on successive sweeps;
  - then 0xE000, 0xC000, 0xA000, 0x8000, with SUSTAIN entered at 0x8000;
  - on gate low, 0x7000 … 0x0 after 8 sweeps, `active[2]` drops when the level reaches 0, and `voice_volumes[2]` is updated only on the edge ending `div`==2.
- **Zero steps:** all steps 0, sustain 0x20000 → on gate rise, a single slot jumps to 0x10000, the next slot goes to SUSTAIN at 0x10000 (clamped), and release reaches 0 in one slot.
- **Retrigger:** gate low during RELEASE at 0x6000, then high again → next slot is ATTACK from 0x6000, giving 0xA000 with attack 0x4000.
- **Short pulse:** a 1-clock gate pulse on voice 5 at `div`=9 → slot 5 gives level = `attack_step`, and the following slot enters RELEASE.
- **Independence and overflow:** voices 0 and 7 gated in the same cycle update independently. With attack_step 0xFFFF_FFFF, the first attack slot saturates to 0x10000 with no wrap.
